// File: rtl/benchmark_sequencer.sv
// benchmark_sequencer: issues NUM_OPS ops under NUM_CONDS conditions to an external unit,
// accumulates WAIT cycles per condition, flags timeouts and selects the fastest condition.
module benchmark_sequencer #(
   parameter int NUM_OPS   = 9,
   parameter int NUM_CONDS = 4,
   parameter int CNT_W     = 32,
   parameter int TIMEOUT   = 51,
   parameter int OP_W      = 4,
   parameter int CW        = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic [2*NUM_OPS-1:0]         route_map,
   output logic                         exe_valid,
   output logic [OP_W-1:0]              exe_op,
   output logic [1:0]                   exe_base,
   output logic [CW-1:0]                exe_cond,
   input  logic                         exe_done,
   output logic [NUM_CONDS*CNT_W-1:0]   cycle_counts,
   output logic [NUM_CONDS-1:0]         timeout_flags,
   output logic [CW-1:0]                winner,
   output logic                         busy,
   output logic                         done
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [OP_W-1:0] LAST_OP   = OP_W'(NUM_OPS - 1);
   localparam logic [CW-1:0]   LAST_COND = CW'(NUM_CONDS - 1);
   localparam logic [TW-1:0]   LAST_WAIT = TW'(TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, COMPARE, DONE} state_t;
   state_t            state;
   logic [OP_W-1:0]   op, nxt_op;
   logic [CW-1:0]     cond, nxt_cond, best, cand;
   logic [TW-1:0]     wait_cnt;
   logic [CNT_W-1:0]  counts [NUM_CONDS];
   logic [1:0]        rmap [NUM_OPS];
   logic              go;
   for (genvar i = 0; i < NUM_OPS; i++) begin : g_rmap
      assign rmap[i] = route_map[2*i +: 2];
   end
   for (genvar i = 0; i < NUM_CONDS; i++) begin : g_cnt
      assign cycle_counts[i*CNT_W +: CNT_W] = counts[i];
   end
   // go: an op is issued on the next edge, either starting a run or stepping from NEXT
   always_comb begin
      go       = state == IDLE ? start : state == NEXT && !(op == LAST_OP && cond == LAST_COND);
      nxt_op   = state == NEXT && op != LAST_OP ? op + 1'b1 : '0;
      nxt_cond = state != NEXT ? '0 : op == LAST_OP ? cond + 1'b1 : cond;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         op            <= '0;
         cond          <= '0;
         best          <= '0;
         cand          <= '0;
         wait_cnt      <= '0;
         for (int i = 0; i < NUM_CONDS; i++) counts[i] <= '0;
         timeout_flags <= '0;
         winner        <= '0;
         exe_valid     <= 1'b0;
         exe_op        <= '0;
         exe_base      <= '0;
         exe_cond      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else if (abort && state != IDLE) begin
         state     <= IDLE;
         exe_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         exe_valid <= go;
         case (state)
            IDLE: if (start) begin
               for (int i = 0; i < NUM_CONDS; i++) counts[i] <= '0;
               timeout_flags <= '0;
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               counts[cond] <= &counts[cond] ? counts[cond] : counts[cond] + 1'b1;
               wait_cnt     <= wait_cnt + 1'b1;
               if (exe_done) state <= NEXT;
               else if (wait_cnt == LAST_WAIT) begin
                  timeout_flags[cond] <= 1'b1;
                  state               <= NEXT;
               end
            end
            NEXT: if (!go) begin
               op    <= '0;
               best  <= '0;
               cand  <= CW'(1);
               state <= COMPARE;
            end
            COMPARE: begin
               if (counts[cand] < counts[best]) best <= cand;
               if (cand == LAST_COND) begin
                  winner <= counts[cand] < counts[best] ? cand : best;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else cand <= cand + 1'b1;
            end
            DONE: if (!start) begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (go) begin
            op       <= nxt_op;
            cond     <= nxt_cond;
            exe_op   <= nxt_op;
            exe_cond <= nxt_cond;
            exe_base <= nxt_cond == LAST_COND ? rmap[nxt_op] : 2'(nxt_cond);
            busy     <= 1'b1;
            state    <= ISSUE;
         end
      end
   end
endmodule
